// File: rtl/cpu_debug_vjtag_scan_master_if.sv
// Signal bundle between the scan master, its command/response client and
// the virtual-JTAG debug slave. "master" is the view of the scan master
// itself; "slave" is the view of everything on the other side (the command
// issuer plus the debug slave's vji_* inputs/outputs).
interface cpu_debug_vjtag_scan_master_if #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2
);
  // Command channel
  logic                cmd_valid;
  logic                cmd_ready;
  logic [IR_WIDTH-1:0] cmd_ir;
  logic [DR_WIDTH-1:0] cmd_data;

  // Response channel
  logic                rsp_valid;
  logic                rsp_ready;
  logic [DR_WIDTH-1:0] rsp_data;
  logic [IR_WIDTH-1:0] rsp_ir_out;

  // Virtual-JTAG side
  logic                vji_tck;
  logic                vji_tdi;
  logic                vji_tdo;
  logic [IR_WIDTH-1:0] vji_ir_in;
  logic [IR_WIDTH-1:0] vji_ir_out;
  logic                vji_rti;
  logic                vji_uir;
  logic                vji_cdr;
  logic                vji_sdr;
  logic                vji_udr;

  modport master (
    input  cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
    output cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
           vji_tck, vji_tdi, vji_ir_in,
           vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
  );

  modport slave (
    output cmd_valid, cmd_ir, cmd_data, rsp_ready, vji_tdo, vji_ir_out,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out,
           vji_tck, vji_tdi, vji_ir_in,
           vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
  );
endinterface

// File: rtl/cpu_debug_vjtag_scan_master.sv
// Initiator side of the CPU debug-slave virtual-JTAG link. One command
// (IR value + DR payload) produces the sequence UIR, CDR, DR_WIDTH x SDR,
// UDR on the vji_* strobes with a divided, registered tck, and returns the
// captured tdo bits together with the ir_out value seen during UIR.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | run-test-idle, cmd_ready=1, waiting for a command
// UIR   | one tck period driving the IR; ir_out sampled on the rising tck
// CDR   | one tck period; tdi pre-loaded with the first payload bit
// SDR   | DR_WIDTH tck periods; tdo captured on rise, tdi shifted on fall
// UDR   | one tck period; capture moved to rsp_data on the final fall
// RSP   | tck parked low, all strobes low, response held until rsp_ready
module cpu_debug_vjtag_scan_master #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_DIV  = 2
) (
  input logic                          clk,
  input logic                          reset_n,
  cpu_debug_vjtag_scan_master_if.master bus
);

  localparam int DIV_W = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam int BIT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(TCK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UIR,
    S_CDR,
    S_SDR,
    S_UDR,
    S_RSP
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [BIT_W-1:0]    bit_q;
  logic                tck_q;
  logic                tdi_q;
  logic [DR_WIDTH-1:0] shift_q;
  logic [DR_WIDTH-1:0] cap_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [IR_WIDTH-1:0] rsp_ir_out_q;
  logic [DR_WIDTH-1:0] rsp_data_q;
  logic                rsp_valid_q;
  logic                cmd_ready_q;
  logic                rti_q;
  logic                uir_q;
  logic                cdr_q;
  logic                sdr_q;
  logic                udr_q;

  logic                active;
  logic                div_tc;
  logic                rise;
  logic                fall;
  logic [DR_WIDTH-1:0] shift_nxt;
  logic [DR_WIDTH-1:0] cap_nxt;

  // tck only runs while a scan is in progress; rise/fall mark the clk cycle
  // whose closing edge flips tck up or down.
  assign active    = (state_q == S_UIR) || (state_q == S_CDR) ||
                     (state_q == S_SDR) || (state_q == S_UDR);
  assign div_tc    = (div_q == DIV_TC);
  assign rise      = active && div_tc && !tck_q;
  assign fall      = active && div_tc &&  tck_q;
  assign shift_nxt = shift_q >> 1;

  // New tdo bit enters at the top so the first captured bit ends up at [0].
  if (DR_WIDTH == 1) begin : g_cap_one
    assign cap_nxt = bus.vji_tdo;
  end else begin : g_cap_many
    assign cap_nxt = {bus.vji_tdo, cap_q[DR_WIDTH-1:1]};
  end

  // Scan sequencer: tck divider, state walk and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      div_q        <= '0;
      bit_q        <= '0;
      tck_q        <= 1'b0;
      tdi_q        <= 1'b0;
      shift_q      <= '0;
      cap_q        <= '0;
      ir_in_q      <= '0;
      rsp_ir_out_q <= '0;
      rsp_data_q   <= '0;
      rsp_valid_q  <= 1'b0;
      cmd_ready_q  <= 1'b1;
      rti_q        <= 1'b1;
      uir_q        <= 1'b0;
      cdr_q        <= 1'b0;
      sdr_q        <= 1'b0;
      udr_q        <= 1'b0;
    end else begin
      if (active) begin
        if (div_tc) begin
          div_q <= '0;
          tck_q <= ~tck_q;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            shift_q     <= bus.cmd_data;
            ir_in_q     <= bus.cmd_ir;
            cap_q       <= '0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            cmd_ready_q <= 1'b0;
            rti_q       <= 1'b0;
            uir_q       <= 1'b1;
            state_q     <= S_UIR;
          end
        end

        S_UIR: begin
          if (rise) begin
            rsp_ir_out_q <= bus.vji_ir_out;
          end
          if (fall) begin
            tdi_q   <= shift_q[0];
            uir_q   <= 1'b0;
            cdr_q   <= 1'b1;
            state_q <= S_CDR;
          end
        end

        S_CDR: begin
          if (fall) begin
            bit_q   <= '0;
            cdr_q   <= 1'b0;
            sdr_q   <= 1'b1;
            state_q <= S_SDR;
          end
        end

        S_SDR: begin
          if (rise) begin
            cap_q <= cap_nxt;
          end
          if (fall) begin
            shift_q <= shift_nxt;
            tdi_q   <= shift_nxt[0];
            if (bit_q == BIT_LAST) begin
              sdr_q   <= 1'b0;
              udr_q   <= 1'b1;
              state_q <= S_UDR;
            end else begin
              bit_q <= bit_q + BIT_W'(1);
            end
          end
        end

        S_UDR: begin
          if (fall) begin
            rsp_data_q  <= cap_q;
            rsp_valid_q <= 1'b1;
            udr_q       <= 1'b0;
            state_q     <= S_RSP;
          end
        end

        S_RSP: begin
          // ir_in deliberately keeps the last command's value here.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            rti_q       <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_ir_out = rsp_ir_out_q;
  assign bus.vji_tck    = tck_q;
  assign bus.vji_tdi    = tdi_q;
  assign bus.vji_ir_in  = ir_in_q;
  assign bus.vji_rti    = rti_q;
  assign bus.vji_uir    = uir_q;
  assign bus.vji_cdr    = cdr_q;
  assign bus.vji_sdr    = sdr_q;
  assign bus.vji_udr    = udr_q;

endmodule

// File: tb/tb_cpu_debug_vjtag_scan_master.sv
// Bench for the virtual-JTAG scan master. Stimulus pushes the expected
// response into a queue; a negedge monitor pops and compares on each
// response handshake and also watches strobe/tck behaviour every cycle.
// A second small instance exercises the fastest tck and a 4-bit chain.
module tb_cpu_debug_vjtag_scan_master;

  localparam int DRW   = 38;
  localparam int IRW   = 2;
  localparam int TD    = 2;
  localparam int LAT   = (DRW + 3) * 2 * TD;
  localparam int DRW_B = 4;
  localparam int TD_B  = 1;
  localparam int LAT_B = (DRW_B + 3) * 2 * TD_B;

  typedef struct {
    logic [DRW-1:0] data;
    logic [IRW-1:0] ir_out;
    logic [IRW-1:0] ir_in;
    int             acc_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  exp_t sb_q[$];

  // tdo source: 0 = loopback of tdi, 1 = constant one, 2 = random pattern
  int             tdo_mode = 0;
  logic [DRW-1:0] pat_q = '0;
  int             pat_idx = 0;
  logic           pat_bit;

  cpu_debug_vjtag_scan_master_if #(.DR_WIDTH(DRW), .IR_WIDTH(IRW)) bus ();
  cpu_debug_vjtag_scan_master_if #(.DR_WIDTH(DRW_B), .IR_WIDTH(IRW)) busb ();

  cpu_debug_vjtag_scan_master #(.DR_WIDTH(DRW), .IR_WIDTH(IRW), .TCK_DIV(TD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  cpu_debug_vjtag_scan_master #(.DR_WIDTH(DRW_B), .IR_WIDTH(IRW), .TCK_DIV(TD_B)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (busb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign pat_bit      = (pat_idx < DRW) ? pat_q[pat_idx] : 1'b0;
  assign bus.vji_tdo  = (tdo_mode == 0) ? bus.vji_tdi : (tdo_mode == 1) ? 1'b1 : pat_bit;
  assign busb.vji_tdo = busb.vji_tdi;

  // Pattern bit k is what the slave presents for the k-th shifted bit.
  always @(posedge bus.vji_tck) begin
    if (bus.vji_uir) pat_idx <= 0;
    else if (bus.vji_sdr) pat_idx <= pat_idx + 1;
  end

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  int   ind;
  int   uir_run = 0, cdr_run = 0, sdr_run = 0, udr_run = 0;
  int   sdr_rises = 0;
  logic prev_valid = 1'b0, prev_tck = 1'b0, prev_sdr = 1'b0;
  logic [DRW-1:0] hold_data;
  logic [IRW-1:0] hold_ir;
  exp_t mon_e;

  function automatic void track(input string nm, input logic on, inout int run, input int want);
    if (on) run++;
    else if (run != 0) begin
      chk(nm, 64'(run), 64'(want));
      run = 0;
    end
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      uir_run = 0; cdr_run = 0; sdr_run = 0; udr_run = 0; sdr_rises = 0;
      prev_valid = 1'b0; prev_tck = 1'b0; prev_sdr = 1'b0;
    end else begin
      ind = int'(bus.vji_rti) + int'(bus.vji_uir) + int'(bus.vji_cdr) +
            int'(bus.vji_sdr) + int'(bus.vji_udr);
      if (bus.rsp_valid) begin
        chk("strobes_in_rsp", 64'(ind), 64'(0));
        chk("tck_in_rsp", 64'(bus.vji_tck), 64'(0));
        chk("cmd_ready_in_rsp", 64'(bus.cmd_ready), 64'(0));
      end else begin
        chk("strobe_onehot", 64'(ind), 64'(1));
      end
      track("uir_len", bus.vji_uir, uir_run, 2 * TD);
      track("cdr_len", bus.vji_cdr, cdr_run, 2 * TD);
      track("udr_len", bus.vji_udr, udr_run, 2 * TD);
      track("sdr_len", bus.vji_sdr, sdr_run, DRW * 2 * TD);
      if (bus.vji_sdr && bus.vji_tck && !prev_tck) sdr_rises++;
      if (!bus.vji_sdr && prev_sdr) begin
        chk("sdr_tck_periods", 64'(sdr_rises), 64'(DRW));
        sdr_rises = 0;
      end
      if ((bus.vji_uir || bus.vji_cdr || bus.vji_sdr || bus.vji_udr) && sb_q.size() > 0)
        chk("ir_in_held", 64'(bus.vji_ir_in), 64'(sb_q[0].ir_in));
      if (bus.rsp_valid && !prev_valid) begin
        if (sb_q.size() == 0) chk("unexpected_rsp", 64'(1), 64'(0));
        else chk("latency", 64'(cyc - sb_q[0].acc_cyc), 64'(LAT));
        hold_data = bus.rsp_data;
        hold_ir   = bus.rsp_ir_out;
      end else if (bus.rsp_valid) begin
        chk("rsp_data_stable", 64'(bus.rsp_data), 64'(hold_data));
        chk("rsp_ir_stable", 64'(bus.rsp_ir_out), 64'(hold_ir));
      end
      if (bus.rsp_valid && bus.rsp_ready && sb_q.size() > 0) begin
        mon_e = sb_q.pop_front();
        chk("rsp_data", 64'(bus.rsp_data), 64'(mon_e.data));
        chk("rsp_ir_out", 64'(bus.rsp_ir_out), 64'(mon_e.ir_out));
      end
      prev_valid = bus.rsp_valid;
      prev_tck   = bus.vji_tck;
      prev_sdr   = bus.vji_sdr;
    end
  end

  // ---------------- stimulus ----------------
  // Called just after a posedge; returns cyc value following the accept edge.
  task automatic run_cmd(input logic [IRW-1:0] ir, input logic [DRW-1:0] data, input int mode,
                         input logic [IRW-1:0] irout, input logic [DRW-1:0] pat, output int acc);
    exp_t e;
    bit   got;
    got = 1'b0;
    tdo_mode       = mode;
    pat_q          = pat;
    bus.vji_ir_out = irout;
    bus.cmd_ir     = ir;
    bus.cmd_data   = data;
    bus.cmd_valid  = 1'b1;
    e.data   = (mode == 0) ? data : (mode == 1) ? {DRW{1'b1}} : pat;
    e.ir_out = irout;
    e.ir_in  = ir;
    for (int i = 0; i < 1000; i++) begin
      if (bus.cmd_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) begin
      chk("accept_timeout", 64'(0), 64'(1));
      bus.cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk); #1;
    e.acc_cyc = cyc;
    acc       = cyc;
    sb_q.push_back(e);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (sb_q.size() == 0 && bus.cmd_ready) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("response_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int             acc, acc2, hs, flat;
    bit             got;
    logic [63:0]    r64, p64;
    logic [IRW-1:0] rir, rirout;
    logic           prevb;

    bus.cmd_valid = 1'b0; bus.cmd_ir = '0; bus.cmd_data = '0;
    bus.rsp_ready = 1'b1; bus.vji_ir_out = '0;
    busb.cmd_valid = 1'b0; busb.cmd_ir = '0; busb.cmd_data = '0;
    busb.rsp_ready = 1'b1; busb.vji_ir_out = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("rst_rti", 64'(bus.vji_rti), 64'(1));
    chk("rst_strobes", 64'({bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr}), 64'(0));
    chk("rst_tck", 64'(bus.vji_tck), 64'(0));
    chk("rst_tdi", 64'(bus.vji_tdi), 64'(0));
    chk("rst_ir_in", 64'(bus.vji_ir_in), 64'(0));
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("rst_rsp_data", 64'(bus.rsp_data), 64'(0));
    chk("rst_rsp_ir_out", 64'(bus.rsp_ir_out), 64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Loopback with the reference payload
    run_cmd(2'b01, 38'h2A_5A5A_5A5A, 0, 2'b11, '0, acc);
    wait_idle();

    // Constant-one tdo, ir_out=10
    run_cmd(2'b01, 38'h15_0F0F_1234, 1, 2'b10, '0, acc);
    wait_idle();

    // Response back-pressure and second command gating
    bus.rsp_ready = 1'b0;
    run_cmd(2'b10, 38'h01_2345_6789, 0, 2'b01, '0, acc);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("hold_rsp_seen", 64'(got), 64'(1));
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = 38'h3A_AAAA_0001;
    bus.cmd_ir    = 2'b11;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
    end
    chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    chk("hold_no_accept", 64'(bus.vji_uir), 64'(0));
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    hs = cyc;
    chk("hs_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("hs_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    run_cmd(2'b11, 38'h3A_AAAA_0001, 0, 2'b00, '0, acc2);
    chk("accept_after_hs", 64'(acc2 - hs), 64'(1));
    wait_idle();

    // Reset during bit 20 of SDR
    run_cmd(2'b01, 38'h0F_F00F_F00F, 0, 2'b01, '0, acc);
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (bus.vji_sdr && sdr_rises == 20 && !bus.vji_tck) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_bit20", 64'(got), 64'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_tck", 64'(bus.vji_tck), 64'(0));
    chk("abort_sdr", 64'(bus.vji_sdr), 64'(0));
    chk("abort_rti", 64'(bus.vji_rti), 64'(1));
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    chk("abort_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    sb_q.delete();
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_cmd(2'b10, 38'h33_CCCC_3333, 0, 2'b10, '0, acc);
    wait_idle();

    // Randomised transactions
    for (int t = 0; t < 10; t++) begin
      r64    = {$urandom, $urandom};
      p64    = {$urandom, $urandom};
      rir    = IRW'($urandom_range(0, 3));
      rirout = IRW'($urandom_range(0, 3));
      run_cmd(rir, r64[DRW-1:0], int'($urandom_range(0, 2)), rirout, p64[DRW-1:0], acc);
      wait_idle();
    end

    // Fast divider, 4-bit chain, loopback
    busb.cmd_data  = 4'b1001;
    busb.cmd_ir    = 2'b11;
    busb.cmd_valid = 1'b1;
    chk("b_cmd_ready", 64'(busb.cmd_ready), 64'(1));
    @(posedge clk); #1;
    acc = cyc;
    busb.cmd_valid = 1'b0;
    got   = 1'b0;
    flat  = 0;
    prevb = busb.vji_tck;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (busb.rsp_valid) begin
        got = 1'b1;
        chk("b_latency", 64'(cyc - acc), 64'(LAT_B));
        chk("b_rsp_data", 64'(busb.rsp_data), 64'(4'b1001));
        break;
      end
      if (busb.vji_tck == prevb) flat++;
      prevb = busb.vji_tck;
    end
    chk("b_rsp_seen", 64'(got), 64'(1));
    chk("b_tck_period2", 64'(flat), 64'(0));
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
